vga_pixel_feeder: RTL and testbench

- Upstream neighbour of the VGA timing controller. Answers its per-pixel request/coordinate stream with 10-bit R/G/B, one cycle after each request.
- Pixels come from a show-ahead RGB565 read FIFO that the SDRAM frame-buffer reader fills.
- Handles frame alignment, FIFO underflow recovery and a colour-bar test mode.

---
 rtl/vga_pixel_feeder.sv | 162 ++++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_feeder.sv
// Pixel source for the VGA timing controller: answers each pixel request one cycle later with
// 10-bit RGB taken from a show-ahead RGB565 FIFO, colour bars, or an underflow fill colour.
module vga_pixel_feeder #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter logic [15:0] UF_COLOR = 16'hF81F,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iRequest,
  input  logic [9:0]       iCoord_X,
  input  logic [9:0]       iCoord_Y,
  input  logic [15:0]      iFifo_Data,
  input  logic             iFifo_Empty,
  output logic             oFifo_Rd,
  output logic             oFifo_Flush,
  input  logic             iTest_En,
  input  logic             iClr_Err,
  output logic [9:0]       oRed,
  output logic [9:0]       oGreen,
  output logic [9:0]       oBlue,
  output logic             oValid,
  output logic             oUnderflow,
  output logic [CNT_W-1:0] oUf_Cnt,
  output logic [1:0]       oState
);

  localparam logic [1:0] StSync  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [9:0] XLast = 10'(H_ACT - 1);
  localparam logic [9:0] YLast = 10'(V_ACT - 1);
  localparam logic [9:0] XEnd  = 10'(H_ACT);
  localparam logic [9:0] BarW  = 10'(H_ACT / 8);

  logic [1:0]       state_q, state_d;
  logic             test_act_q, test_act_d;
  logic             flush_q, flush_d;
  logic [29:0]      rgb_q, rgb_d;
  logic             valid_q;
  logic             under_q, under_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        fs, le, test_next, rd, uf_evt;
  logic [9:0]  bar_div;
  logic [2:0]  bar_idx;
  logic [15:0] bar_color;

  function automatic logic [29:0] expand565(input logic [15:0] c);
    return {c[15:11], c[15:11], c[10:5], c[10:7], c[4:0], c[4:0]};
  endfunction

  always_comb begin
    fs        = iRequest && (iCoord_X == 10'd0) && (iCoord_Y == 10'd0);
    le        = iRequest && (iCoord_X == XLast) && (iCoord_Y == YLast);
    // Test mode takes effect on the frame-start pixel that requests it.
    test_next = fs ? iTest_En : test_act_q;
    rd        = iRequest && !iFifo_Empty && !test_next && !iRST &&
                ((state_q == StRun) || ((state_q == StSync) && fs));
    uf_evt    = iRequest && iFifo_Empty && !test_next && (state_q == StRun);
  end

  always_comb begin
    bar_div = iCoord_X / BarW;
    bar_idx = ((iCoord_X >= XEnd) || (bar_div > 10'd7)) ? 3'd7 : bar_div[2:0];
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  always_comb begin
    rgb_d = '0;
    if (iRequest) begin
      if (rd) begin
        rgb_d = expand565(iFifo_Data);
      end else if (test_next) begin
        rgb_d = expand565(bar_color);
      end else if (uf_evt || (state_q == StDrain)) begin
        rgb_d = expand565(UF_COLOR);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    test_act_d = test_next;
    if (test_next) begin
      state_d = StSync;
      flush_d = fs && !test_act_q;
    end else begin
      case (state_q)
        StSync: begin
          if (fs && !iFifo_Empty) state_d = StRun;
        end
        StRun: begin
          if (uf_evt) begin
            state_d = le ? StSync : StDrain;
            flush_d = le;
          end
        end
        StDrain: begin
          if (le) begin
            state_d = StSync;
            flush_d = 1'b1;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  // Clear is applied before a same-cycle underflow so the new event is never lost.
  always_comb begin
    under_d = iClr_Err ? 1'b0 : under_q;
    cnt_d   = iClr_Err ? '0 : cnt_q;
    if (uf_evt) begin
      under_d = 1'b1;
      if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StSync;
      test_act_q <= 1'b0;
      flush_q    <= 1'b0;
      rgb_q      <= '0;
      valid_q    <= 1'b0;
      under_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      test_act_q <= test_act_d;
      flush_q    <= flush_d;
      rgb_q      <= rgb_d;
      valid_q    <= iRequest;
      under_q    <= under_d;
      cnt_q      <= cnt_d;
    end
  end

  assign oFifo_Rd    = rd;
  assign oFifo_Flush = flush_q;
  assign oRed        = rgb_q[29:20];
  assign oGreen      = rgb_q[19:10];
  assign oBlue       = rgb_q[9:0];
  assign oValid      = valid_q;
  assign oUnderflow  = under_q;
  assign oUf_Cnt     = cnt_q;
  assign oState      = state_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Scoreboard bench for vga_pixel_feeder: a behavioural model predicts pops, flags and pixels;
// a negedge monitor pops expected pixels whenever oValid is presented.
module tb_vga_pixel_feeder;

  localparam int unsigned H_ACT = 640;
  localparam int unsigned V_ACT = 480;
  localparam int unsigned CNT_W = 10;
  localparam logic [15:0] UF_COLOR = 16'hF81F;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SYNC = 0, RUN = 1, DRAIN = 2;

  logic             iCLK, iRST, iRequest, iFifo_Empty, iTest_En, iClr_Err;
  logic [9:0]       iCoord_X, iCoord_Y;
  logic [15:0]      iFifo_Data;
  logic             oFifo_Rd, oFifo_Flush, oValid, oUnderflow;
  logic [9:0]       oRed, oGreen, oBlue;
  logic [CNT_W-1:0] oUf_Cnt;
  logic [1:0]       oState;

  vga_pixel_feeder #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .UF_COLOR(UF_COLOR), .CNT_W(CNT_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iRequest(iRequest), .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
    .iFifo_Data(iFifo_Data), .iFifo_Empty(iFifo_Empty), .oFifo_Rd(oFifo_Rd),
    .oFifo_Flush(oFifo_Flush), .iTest_En(iTest_En), .iClr_Err(iClr_Err), .oRed(oRed),
    .oGreen(oGreen), .oBlue(oBlue), .oValid(oValid), .oUnderflow(oUnderflow),
    .oUf_Cnt(oUf_Cnt), .oState(oState)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int          tests = 0, fails = 0;
  bit          mon_en = 0;
  int          m_state;
  bit          m_test, m_under, m_flush;
  int          m_cnt;
  bit          cur_test_en, cur_clr;
  logic [15:0] fifo[$];
  logic [29:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 565 -> 10 bit by replication is the same as scaling with these integer factors.
  function automatic logic [29:0] exp_rgb(input logic [15:0] c);
    int r, g, b;
    r = int'(c[15:11]);
    g = int'(c[10:5]);
    b = int'(c[4:0]);
    return {10'(r * 33), 10'(g * 16 + g / 4), 10'(b * 33)};
  endfunction

  function automatic logic [15:0] bar_color(input int x);
    int b;
    b = x / (H_ACT / 8);
    if (b > 7) b = 7;
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge iCLK) begin
    if (mon_en) begin
      if (oValid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra_valid: got valid pixel %0h expected no pixel",
                   {oRed, oGreen, oBlue});
        end else begin
          chk("pixel", 32'({oRed, oGreen, oBlue}), 32'(sb.pop_front()));
        end
      end else begin
        chk("idle_black", 32'({oRed, oGreen, oBlue}), 32'd0);
      end
    end
  end

  task automatic step(input bit req, input int x, input int y);
    bit empty, fs, le, tn, rd, uf;
    logic [29:0] pix;
    empty       = (fifo.size() == 0);
    iRequest    = req;
    iCoord_X    = 10'(x);
    iCoord_Y    = 10'(y);
    iTest_En    = cur_test_en;
    iClr_Err    = cur_clr;
    iFifo_Empty = empty;
    iFifo_Data  = empty ? 16'($urandom) : fifo[0];
    fs = req && x == 0 && y == 0;
    le = req && x == H_ACT - 1 && y == V_ACT - 1;
    tn = fs ? cur_test_en : m_test;
    rd = req && !empty && !tn && (m_state == RUN || (m_state == SYNC && fs));
    uf = req && empty && !tn && m_state == RUN;
    if (req) begin
      if (rd) pix = exp_rgb(fifo[0]);
      else if (tn) pix = exp_rgb(bar_color(x));
      else if (uf || m_state == DRAIN) pix = exp_rgb(UF_COLOR);
      else pix = '0;
      sb.push_back(pix);
    end
    #1;
    chk("fifo_rd", 32'(oFifo_Rd), 32'(rd));
    @(posedge iCLK);
    if (rd) void'(fifo.pop_front());
    m_flush = 0;
    if (tn) begin
      m_flush = fs && !m_test;
      m_state = SYNC;
    end else if (m_state == SYNC) begin
      if (fs && !empty) m_state = RUN;
    end else if (uf || m_state == DRAIN) begin
      if (le) begin
        m_state = SYNC;
        m_flush = 1;
      end else begin
        m_state = DRAIN;
      end
    end
    if (fs) m_test = cur_test_en;
    if (cur_clr) begin
      m_under = 0;
      m_cnt   = 0;
    end
    if (uf) begin
      m_under = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    chk("flush", 32'(oFifo_Flush), 32'(m_flush));
    chk("state", 32'(oState), 32'(m_state));
    chk("underflow", 32'(oUnderflow), 32'(m_under));
    chk("uf_cnt", 32'(oUf_Cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    iRST = 1; iRequest = 0; iCoord_X = '0; iCoord_Y = '0;
    cur_test_en = 0; cur_clr = 0; iTest_En = 0; iClr_Err = 0;
    iFifo_Empty = 1; iFifo_Data = '0;
    @(posedge iCLK);
    m_state = SYNC; m_test = 0; m_under = 0; m_cnt = 0; m_flush = 0;
    #1;
    iRST = 0;
    chk("rst_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_flush", 32'(oFifo_Flush), 32'd0);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_under", 32'(oUnderflow), 32'd0);
    chk("rst_cnt", 32'(oUf_Cnt), 32'd0);
  endtask

  initial begin
    int bars[10];
    do_reset();
    mon_en = 1;

    // Frame start with two words queued.
    fifo.push_back(16'hF800);
    fifo.push_back(16'h07E0);
    step(1, 0, 0);
    chk("t1_red", 32'(oRed), 32'h3FF);
    chk("t1_green0", 32'(oGreen), 32'h000);
    step(1, 1, 0);
    chk("t1_green1", 32'(oGreen), 32'h3FF);
    chk("t1_state", 32'(oState), 32'd1);
    step(0, 0, 0);

    // Underflow mid-frame, drain to last pixel, then an empty frame start.
    for (int i = 0; i < 10; i++) fifo.push_back(16'($urandom));
    for (int i = 0; i < 10; i++) step(1, i + 2, 0);
    step(1, 100, 10);
    chk("t2_uf_rgb", 32'({oRed, oGreen, oBlue}), 32'({10'h3FF, 10'h000, 10'h3FF}));
    chk("t2_uf_cnt", 32'(oUf_Cnt), 32'd1);
    chk("t2_state", 32'(oState), 32'd2);
    step(1, 101, 10);
    fifo.push_back(16'h1234);
    step(1, 200, 300);
    step(1, 639, 479);
    chk("t2_flush", 32'(oFifo_Flush), 32'd1);
    step(0, 0, 0);
    fifo.delete();
    step(1, 0, 0);
    step(1, 5, 5);
    fifo.push_back(16'hABCD);
    step(1, 6, 5);
    step(1, 639, 479);
    step(1, 0, 0);
    chk("t2_resync", 32'(oState), 32'd1);
    cur_clr = 1;
    step(0, 0, 0);
    cur_clr = 0;

    // Test mode requested mid-frame only takes effect at the next frame start.
    for (int i = 0; i < 4; i++) fifo.push_back(16'($urandom));
    step(1, 1, 0);
    cur_test_en = 1;
    step(1, 50, 5);
    step(1, 51, 5);
    step(1, 0, 0);
    chk("t3_bar0", 32'({oRed, oGreen, oBlue}), 32'({10'h3FF, 10'h3FF, 10'h3FF}));
    chk("t3_flush", 32'(oFifo_Flush), 32'd1);
    bars = '{80, 160, 240, 320, 400, 480, 560, 639, 700, 1000};
    foreach (bars[i]) begin
      step(1, bars[i], 7);
      if (i == 0) chk("t3_bar1", 32'({oRed, oGreen, oBlue}), 32'({10'h3FF, 10'h3FF, 10'h0}));
      if (i == 7) chk("t3_bar7", 32'({oRed, oGreen, oBlue}), 32'd0);
    end
    step(1, 639, 479);
    step(1, 0, 0);
    cur_test_en = 0;
    step(1, 639, 479);
    step(1, 0, 0);
    chk("t3_exit", 32'(oState), 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int sel, x, y;
      if ($urandom_range(0, 9) < 7 && fifo.size() < 6) fifo.push_back(16'($urandom));
      if ($urandom_range(0, 99) == 0) cur_test_en = !cur_test_en;
      cur_clr = ($urandom_range(0, 49) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        x = 0; y = 0;
      end else if (sel == 2) begin
        x = H_ACT - 1; y = V_ACT - 1;
      end else begin
        x = $urandom_range(0, H_ACT - 1); y = $urandom_range(0, V_ACT - 1);
      end
      step($urandom_range(0, 3) != 0, x, y);
    end
    cur_clr = 0;
    step(0, 0, 0);

    // Saturate the event counter, then clear together with a fresh event.
    do_reset();
    fifo.delete();
    for (int n = 0; n < CNT_MAX + 5; n++) begin
      fifo.push_back(16'($urandom));
      step(1, 0, 0);
      step(1, 639, 479);
    end
    chk("t5_sat", 32'(oUf_Cnt), 32'(CNT_MAX));
    fifo.push_back(16'h5555);
    step(1, 0, 0);
    cur_clr = 1;
    step(1, 639, 479);
    cur_clr = 0;
    chk("t5_clr_cnt", 32'(oUf_Cnt), 32'd1);
    chk("t5_clr_under", 32'(oUnderflow), 32'd1);

    // Reset in the middle of a running frame.
    for (int i = 0; i < 3; i++) fifo.push_back(16'($urandom));
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    do_reset();
    fifo.delete();
    fifo.push_back(16'h0F0F);
    step(1, 3, 0);
    step(1, 0, 0);
    chk("t6_resync", 32'(oState), 32'd1);

    step(0, 0, 0);
    step(0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
